// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
package div_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract, restore on borrow.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             nonneg;

    // One extra bit above the remainder width acts as the borrow/sign of the trial.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        diff     = shifted - {2'b00, divisor};
        nonneg   = ~diff[WIDTH+1];
        rem_next = nonneg ? diff[WIDTH:0] : shifted[WIDTH:0];
        quo_next = {quo[WIDTH-2:0], nonneg};
    end

endmodule

// File: rtl/radix2_restoring_divider.sv
// Iterative unsigned divider: one restoring step per clock, valid/ready on both sides.
module radix2_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int              CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic             dbz_q;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (b_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = (B == '0) ? DONE : CALC;
            CALC: if (count == LAST) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The quotient register starts as the dividend; its bits shift out MSB-first
    // into the remainder while quotient bits shift in at the LSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            b_q   <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        count <= '0;
                        b_q   <= B;
                        if (B == '0) begin
                            quo_q <= '1;
                            rem_q <= {1'b0, A};
                            dbz_q <= 1'b1;
                        end else begin
                            quo_q <= A;
                            rem_q <= '0;
                            dbz_q <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    count <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q[WIDTH-1:0];
    assign div_by_zero = dbz_q;

endmodule
